// File: rtl/bist_resp_analyzer.sv
// bist_resp_analyzer: BIST output response analyzer.
// Compacts the CUT outputs into a MISR signature over N_CYCLES cycles.
// The final signature is then compared against GOLDEN, and the result is
// held in DONE until bist_start drops.
// Optional feature macro: BIST_ORA_ERR_COUNT_EN (saturating error counter).
module bist_resp_analyzer #(
    parameter int          SIG_W    = 16,
    parameter logic [31:0] POLY     = 32'h0000_1021,
    parameter logic [31:0] SEED     = 32'h0000_0000,
    parameter logic [31:0] GOLDEN   = 32'h0000_0000,
    parameter int          N_CYCLES = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             bist_start,
    input  logic             in_synced_d,
    input  logic             in_sync_err_d,
    output logic             busy,
    output logic [SIG_W-1:0] signature,
    output logic             pass_fail,
    output logic             bist_end,
    output logic [7:0]       err_count
);

    localparam int               CNT_W    = $clog2(N_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CYCLES - 1);
    localparam logic [SIG_W-1:0] POLY_T   = POLY[SIG_W-1:0];
    localparam logic [SIG_W-1:0] SEED_T   = SEED[SIG_W-1:0];
    localparam logic [SIG_W-1:0] GOLDEN_T = GOLDEN[SIG_W-1:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COMPRESS,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               start_q;
    logic [SIG_W-1:0]   misr_q, misr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pf_q, pf_d;
    logic               start_rise;
    logic [SIG_W-1:0]   misr_shift;

    // Start is acted on only as a 0->1 transition seen from IDLE.
    assign start_rise = bist_start & ~start_q;

    // One MISR step: shift left, fold MSB back through POLY, inject CUT bits.
    assign misr_shift = {misr_q[SIG_W-2:0], 1'b0}
                      ^ (misr_q[SIG_W-1] ? POLY_T : '0)
                      ^ {{(SIG_W-2){1'b0}}, in_sync_err_d, in_synced_d};

    // State, start history and datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            misr_q  <= SEED_T;
            cnt_q   <= '0;
            pf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= bist_start;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            pf_q    <= pf_d;
        end
    end

    // Next-state logic; start is ignored outside IDLE so a run can't be aborted by it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start_rise) state_d = S_CLEAR;
            S_CLEAR:    state_d = S_COMPRESS;
            S_COMPRESS: if (cnt_q == CNT_LAST) state_d = S_COMPARE;
            S_COMPARE:  state_d = S_DONE;
            S_DONE:     if (!bist_start) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Datapath updates: seed in CLEAR, compress in COMPRESS, verdict in COMPARE.
    always_comb begin
        misr_d = misr_q;
        cnt_d  = cnt_q;
        pf_d   = pf_q;
        case (state_q)
            S_CLEAR: begin
                misr_d = SEED_T;
                cnt_d  = '0;
                pf_d   = 1'b0;
            end
            S_COMPRESS: begin
                misr_d = misr_shift;
                cnt_d  = cnt_q + CNT_W'(1);
            end
            S_COMPARE: begin
                pf_d = (misr_q == GOLDEN_T);
            end
            default: ;
        endcase
    end

`ifdef BIST_ORA_ERR_COUNT_EN
    logic [7:0] ec_q, ec_d;

    // Saturating count of error cycles, only while compressing.
    always_comb begin
        ec_d = ec_q;
        if (state_q == S_CLEAR) begin
            ec_d = 8'h00;
        end else if (state_q == S_COMPRESS && in_sync_err_d && ec_q != 8'hFF) begin
            ec_d = ec_q + 8'h01;
        end
    end

    // Error counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ec_q <= 8'h00;
        end else begin
            ec_q <= ec_d;
        end
    end

    assign err_count = ec_q;
`else
    assign err_count = 8'h00;
`endif

    assign busy      = (state_q == S_CLEAR) || (state_q == S_COMPRESS) || (state_q == S_COMPARE);
    assign bist_end  = (state_q == S_DONE);
    assign signature = misr_q;
    assign pass_fail = pf_q;

endmodule

// File: tb/tb_bist_resp_analyzer.sv
// Testbench for bist_resp_analyzer: four instances with different run lengths,
// seeds and golden values, driven by random CUT responses and compared
// against a sequence-level MISR reference model.
module tb_bist_resp_analyzer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  start = 4'b0000;
    logic        synced = 1'b0;
    logic        err = 1'b0;

    logic [3:0]  busy_v, end_v, pf_v;
    logic [15:0] sig_v [4];
    logic [7:0]  ec_v [4];

    int n_chk  = 0;
    int n_pass = 0;

    bit dv [0:299];
    bit ev [0:299];

    always #5 CLK = ~CLK;

    bist_resp_analyzer #(.SIG_W(16), .N_CYCLES(4), .SEED(32'h0), .GOLDEN(32'h0)) u0 (
        .CLK(CLK), .RST(RST), .bist_start(start[0]), .in_synced_d(synced), .in_sync_err_d(err),
        .busy(busy_v[0]), .signature(sig_v[0]), .pass_fail(pf_v[0]), .bist_end(end_v[0]), .err_count(ec_v[0]));
    bist_resp_analyzer #(.SIG_W(16), .N_CYCLES(4), .SEED(32'h0), .GOLDEN(32'h0008)) u1 (
        .CLK(CLK), .RST(RST), .bist_start(start[1]), .in_synced_d(synced), .in_sync_err_d(err),
        .busy(busy_v[1]), .signature(sig_v[1]), .pass_fail(pf_v[1]), .bist_end(end_v[1]), .err_count(ec_v[1]));
    bist_resp_analyzer #(.SIG_W(16), .N_CYCLES(17), .SEED(32'h0), .GOLDEN(32'h1021)) u2 (
        .CLK(CLK), .RST(RST), .bist_start(start[2]), .in_synced_d(synced), .in_sync_err_d(err),
        .busy(busy_v[2]), .signature(sig_v[2]), .pass_fail(pf_v[2]), .bist_end(end_v[2]), .err_count(ec_v[2]));
    bist_resp_analyzer #(.SIG_W(16), .N_CYCLES(300), .SEED(32'hACE1), .GOLDEN(32'h0)) u3 (
        .CLK(CLK), .RST(RST), .bist_start(start[3]), .in_synced_d(synced), .in_sync_err_d(err),
        .busy(busy_v[3]), .signature(sig_v[3]), .pass_fail(pf_v[3]), .bist_end(end_v[3]), .err_count(ec_v[3]));

    function automatic int nc_of(input int k);
        case (k)
            0: return 4;
            1: return 4;
            2: return 17;
            default: return 300;
        endcase
    endfunction

    function automatic logic [15:0] seed_of(input int k);
        return (k == 3) ? 16'hACE1 : 16'h0000;
    endfunction

    function automatic logic [15:0] gold_of(input int k);
        case (k)
            1: return 16'h0008;
            2: return 16'h1021;
            default: return 16'h0000;
        endcase
    endfunction

    // Reference signature: walk the response sequence as polynomial division
    // over GF(2) with x^16 + x^12 + x^5 + 1, injecting each response pair.
    function automatic logic [15:0] ref_sig(input logic [15:0] seed, input int n);
        int m;
        m = seed;
        for (int i = 0; i < n; i++) begin
            m = m * 2;
            if (m >= 65536) m = (m - 65536) ^ 32'h1021;
            m = m ^ (ev[i] ? 2 : 0) ^ (dv[i] ? 1 : 0);
        end
        return m[15:0];
    endfunction

    function automatic logic [7:0] ref_err(input int n);
        int c;
        c = 0;
`ifdef BIST_ORA_ERR_COUNT_EN
        for (int i = 0; i < n; i++) c += ev[i];
        if (c > 255) c = 255;
`endif
        return c[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // One full run on instance k. mode: 0 zeros, 1 single synced pulse,
    // 2 random, 3 random data with error held high.
    task automatic run_dut(input int k, input int mode, input bit glitch, input string tag);
        int n, edges, j;
        bit seen, busy_ok, others_ok;
        logic [15:0] exp_sig;
        logic [15:0] ob [4];
        n = nc_of(k);
        for (int i = 0; i < n; i++) begin
            case (mode)
                0: begin dv[i] = 1'b0; ev[i] = 1'b0; end
                1: begin dv[i] = (i == 0); ev[i] = 1'b0; end
                2: begin dv[i] = 1'($urandom); ev[i] = 1'($urandom); end
                default: begin dv[i] = 1'($urandom); ev[i] = 1'b1; end
            endcase
        end
        for (int i = 0; i < 4; i++) ob[i] = sig_v[i];
        @(negedge CLK);
        start[k] = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        edges   = 1;
        seen    = 1'b0;
        busy_ok = busy_v[k];
        while (!seen && edges < n + 20) begin
            j = edges - 2;
            if (j >= 0 && j < n) begin
                synced = dv[j];
                err    = ev[j];
            end else begin
                synced = 1'($urandom);
                err    = 1'($urandom);
            end
            if (glitch) start[k] = (j >= -1 && j < n - 1) ? 1'($urandom) : 1'b1;
            @(posedge CLK);
            edges++;
            @(negedge CLK);
            if (end_v[k]) seen = 1'b1;
            else if (!busy_v[k]) busy_ok = 1'b0;
        end
        start[k] = 1'b1;
        // Edges counted include the one that sampled the start rise.
        chk({tag, "_latency"}, edges, n + 3);
        chk({tag, "_busy_run"}, busy_ok, 1);
        exp_sig = ref_sig(seed_of(k), n);
        repeat (3) begin
            synced = 1'($urandom);
            err    = 1'($urandom);
            @(posedge CLK);
            @(negedge CLK);
        end
        chk({tag, "_end_hold"}, end_v[k], 1);
        chk({tag, "_busy_done"}, busy_v[k], 0);
        chk({tag, "_sig"}, sig_v[k], exp_sig);
        chk({tag, "_pf"}, pf_v[k], exp_sig == gold_of(k));
        chk({tag, "_errcnt"}, ec_v[k], ref_err(n));
        start[k] = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk({tag, "_end_drop"}, end_v[k], 0);
        chk({tag, "_sig_idle"}, sig_v[k], exp_sig);
        others_ok = 1'b1;
        for (int i = 0; i < 4; i++)
            if (i != k && sig_v[i] !== ob[i]) others_ok = 1'b0;
        chk({tag, "_others_idle"}, others_ok, 1);
    endtask

    initial begin
        synced = 1'b1;
        err    = 1'b1;
        RST    = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_busy%0d", k), busy_v[k], 0);
            chk($sformatf("rst_end%0d", k), end_v[k], 0);
            chk($sformatf("rst_pf%0d", k), pf_v[k], 0);
            chk($sformatf("rst_sig%0d", k), sig_v[k], seed_of(k));
            chk($sformatf("rst_ec%0d", k), ec_v[k], 0);
        end
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        run_dut(0, 0, 1'b0, "clean");
        run_dut(1, 1, 1'b0, "pulse_gold");
        run_dut(0, 1, 1'b0, "pulse_nogold");
        run_dut(2, 1, 1'b0, "wrap");
        run_dut(2, 2, 1'b1, "glitch");
        for (int r = 0; r < 4; r++) run_dut(r % 2, 2, r[1], $sformatf("rand%0d", r));

        // Abort in the middle of compression: reset acts without a clock edge.
        @(negedge CLK);
        start[2] = 1'b1;
        repeat (10) @(posedge CLK);
        #2;
        chk("abort_busy_before", busy_v[2], 1);
        RST = 1'b1;
        #1;
        chk("abort_busy", busy_v[2], 0);
        chk("abort_end", end_v[2], 0);
        chk("abort_sig", sig_v[2], 16'h0000);
        chk("abort_pf", pf_v[2], 0);
        chk("abort_ec", ec_v[2], 0);
        @(negedge CLK);
        start[2] = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("abort_idle_end", end_v[2], 0);
        run_dut(2, 2, 1'b0, "fresh");

        run_dut(3, 3, 1'b0, "errsat");
        run_dut(3, 2, 1'b1, "long_rand");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
